// File: rtl/regfile_pkg.sv
// Shared sizing constants and FSM state type for the register-bank write port.
package regfile_pkg;

  localparam int unsigned NREQ = 3;
  localparam int unsigned NREG = 8;
  localparam int unsigned AW   = $clog2(NREG);
  localparam int unsigned RW   = $clog2(NREQ);
  localparam int unsigned DW   = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR_LO = 2'd1,
    WR_HI = 2'd2
  } wr_state_e;

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Requester-side request/grant signals and register-bank write outputs.
interface reg_write_arbiter_if;
  import regfile_pkg::*;

  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ-1:0]    req_wide;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    done;
  logic [NREG-1:0]    reg_ce;
  logic [7:0]         reg_d;
  logic               busy;

  modport master (
    output req, req_addr, req_wide, req_data,
    input  gnt, done, reg_ce, reg_d, busy
  );

  modport slave (
    input  req, req_addr, req_wide, req_data,
    output gnt, done, reg_ce, reg_d, busy
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin pick: first requester at or after the pointer, wrapping modulo NREQ.
module rr_arbiter
  import regfile_pkg::*;
(
  input  logic [NREQ-1:0] req_i,
  input  logic [RW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [RW-1:0]   idx_o,
  output logic            vld_o
);

  logic [RW:0] pos;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    pos   = '0;
    for (int k = 0; k < NREQ; k++) begin
      pos = {1'b0, ptr_i} + (RW+1)'(k);
      if (pos >= (RW+1)'(NREQ)) pos = pos - (RW+1)'(NREQ);
      if (!vld_o && req_i[pos[RW-1:0]]) begin
        vld_o               = 1'b1;
        idx_o               = pos[RW-1:0];
        gnt_o[pos[RW-1:0]]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Shares the 8-bit register write bus among requesters; wide writes take two
// consecutive cycles to an even/odd pair, low byte first.
module reg_write_arbiter
  import regfile_pkg::*;
(
  input  logic                 CLK,
  input  logic                 CLR,
  reg_write_arbiter_if.slave   bus
);

  wr_state_e         state_q;
  logic [AW-1:0]     addr_q;
  logic              wide_q;
  logic [DW-1:0]     data_q;
  logic [RW-1:0]     id_q;
  logic [RW-1:0]     ptr_q;
  logic [NREQ-1:0]   done_q;
  logic [NREG-1:0]   ce_q;
  logic [7:0]        d_q;
  logic              busy_q;

  logic [NREQ-1:0]   win_oh;
  logic [RW-1:0]     win_idx;
  logic              win_vld;

  logic              final_c;
  logic              accept_c;
  logic [AW-1:0]     acc_addr_c;
  logic              acc_wide_c;
  logic [DW-1:0]     acc_data_c;
  logic [RW-1:0]     ptr_nxt_c;

  rr_arbiter u_arb (
    .req_i (bus.req),
    .ptr_i (ptr_q),
    .gnt_o (win_oh),
    .idx_o (win_idx),
    .vld_o (win_vld)
  );

  // A new transfer may only start when the bus is free next cycle.
  always_comb begin
    final_c    = (state_q == WR_LO && !wide_q) || (state_q == WR_HI);
    accept_c   = win_vld && ((state_q == IDLE) || final_c);
    acc_wide_c = bus.req_wide[win_idx];
    acc_addr_c = bus.req_addr[win_idx*AW +: AW];
    acc_data_c = bus.req_data[win_idx*DW +: DW];
    if (acc_wide_c) acc_addr_c[0] = 1'b0;
    ptr_nxt_c  = (win_idx == RW'(NREQ-1)) ? '0 : win_idx + RW'(1);
  end

  assign bus.gnt    = accept_c ? win_oh : '0;
  assign bus.done   = done_q;
  assign bus.reg_ce = ce_q;
  assign bus.reg_d  = d_q;
  assign bus.busy   = busy_q;

  // Write FSM; bank strobes are registered alongside the state they belong to.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wide_q  <= 1'b0;
      data_q  <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
      done_q  <= '0;
      ce_q    <= '0;
      d_q     <= '0;
      busy_q  <= 1'b0;
    end else begin
      done_q <= '0;
      ce_q   <= '0;
      d_q    <= '0;
      busy_q <= 1'b0;
      if (accept_c) begin
        state_q         <= WR_LO;
        addr_q          <= acc_addr_c;
        wide_q          <= acc_wide_c;
        data_q          <= acc_data_c;
        id_q            <= win_idx;
        ptr_q           <= ptr_nxt_c;
        ce_q            <= NREG'(1) << acc_addr_c;
        d_q             <= acc_data_c[7:0];
        busy_q          <= 1'b1;
        done_q[win_idx] <= !acc_wide_c;
      end else if (state_q == WR_LO && wide_q) begin
        state_q      <= WR_HI;
        ce_q         <= NREG'(1) << (addr_q | AW'(1));
        d_q          <= data_q[15:8];
        busy_q       <= 1'b1;
        done_q[id_q] <= 1'b1;
      end else begin
        state_q <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench with a write scoreboard: grant checks push expected bank writes,
// a negedge monitor pops and compares them when reg_ce is active.
module tb_reg_write_arbiter;
  import regfile_pkg::*;

  typedef struct {
    int         cyc;
    logic [7:0] ce;
    logic [7:0] d;
    logic [2:0] done;
  } exp_t;

  logic CLK;
  logic CLR;
  int   cyc;
  int   checks;
  int   failures;
  int   t;
  exp_t sbq[$];

  reg_write_arbiter_if bus ();

  reg_write_arbiter dut (
    .CLK (CLK),
    .CLR (CLR),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic w, input logic [15:0] dat);
    bus.req[i]              = 1'b1;
    bus.req_addr[i*AW +: AW] = a;
    bus.req_wide[i]         = w;
    bus.req_data[i*DW +: DW] = dat;
  endtask

  task automatic push(input int c, input logic [7:0] ce, input logic [7:0] d, input logic [2:0] dn);
    exp_t e;
    e.cyc  = c;
    e.ce   = ce;
    e.d    = d;
    e.done = dn;
    sbq.push_back(e);
  endtask

  task automatic grant_is(input string name, input logic [2:0] g);
    @(negedge CLK);
    check(name, 32'(bus.gnt), 32'(g));
    t = cyc;
  endtask

  task automatic all_zero(input string name);
    check({name, "_gnt"},  32'(bus.gnt),    32'h0);
    check({name, "_done"}, 32'(bus.done),   32'h0);
    check({name, "_ce"},   32'(bus.reg_ce), 32'h0);
    check({name, "_d"},    32'(bus.reg_d),  32'h0);
    check({name, "_busy"}, 32'(bus.busy),   32'h0);
  endtask

  // Monitor: every active bank write must match the oldest expected write.
  always @(negedge CLK) begin
    if (!CLR && bus.reg_ce != '0) begin
      if (sbq.size() == 0) begin
        check("unexpected_write", 32'(bus.reg_ce), 32'h0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("wr_cycle", 32'(cyc),       32'(e.cyc));
        check("wr_ce",    32'(bus.reg_ce), 32'(e.ce));
        check("wr_d",     32'(bus.reg_d),  32'(e.d));
        check("wr_done",  32'(bus.done),   32'(e.done));
        check("wr_busy",  32'(bus.busy),   32'h1);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    cyc = 0; checks = 0; failures = 0; t = 0;
    CLR = 1'b1;
    bus.req = '0; bus.req_addr = '0; bus.req_wide = '0; bus.req_data = '0;
    repeat (2) tick();
    @(negedge CLK);
    all_zero("reset");
    tick();
    CLR = 1'b0;

    // single 8-bit write
    set_req(1, 3'd3, 1'b0, 16'h00A5);
    grant_is("single_gnt", 3'b010);
    push(t + 1, 8'h08, 8'hA5, 3'b010);
    tick();
    bus.req[1] = 1'b0;
    tick();
    @(negedge CLK);
    check("single_busy_low", 32'(bus.busy), 32'h0);
    tick();

    // wide write, odd address forced even
    set_req(0, 3'd5, 1'b1, 16'hBEEF);
    grant_is("wide_gnt", 3'b001);
    push(t + 1, 8'h10, 8'hEF, 3'b000);
    push(t + 2, 8'h20, 8'hBE, 3'b001);
    tick();
    bus.req[0] = 1'b0;
    tick();
    tick();

    // contention after reset: 0,1,2,0 back to back
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    set_req(0, 3'd0, 1'b0, 16'h0011);
    set_req(1, 3'd1, 1'b0, 16'h0022);
    set_req(2, 3'd2, 1'b0, 16'h0033);
    grant_is("cont_g0", 3'b001); push(t + 1, 8'h01, 8'h11, 3'b001); tick();
    grant_is("cont_g1", 3'b010); push(t + 1, 8'h02, 8'h22, 3'b010); tick();
    grant_is("cont_g2", 3'b100); push(t + 1, 8'h04, 8'h33, 3'b100); tick();
    grant_is("cont_g3", 3'b001); push(t + 1, 8'h01, 8'h11, 3'b001); tick();
    bus.req = '0;
    grant_is("cont_none", 3'b000);
    tick();

    // fairness after wrap: pointer at 2, req 101
    set_req(1, 3'd6, 1'b0, 16'h0077);
    grant_is("wrap_g1", 3'b010);
    push(t + 1, 8'h40, 8'h77, 3'b010);
    tick();
    bus.req[1] = 1'b0;
    set_req(0, 3'd7, 1'b0, 16'h0088);
    set_req(2, 3'd0, 1'b0, 16'h0099);
    grant_is("wrap_g2", 3'b100);
    push(t + 1, 8'h01, 8'h99, 3'b100);
    tick();
    bus.req[2] = 1'b0;
    grant_is("wrap_g0", 3'b001);
    push(t + 1, 8'h80, 8'h88, 3'b001);
    tick();
    bus.req[0] = 1'b0;
    tick();

    // wide from 2, late request from 0 waits for WR_HI
    set_req(2, 3'd2, 1'b1, 16'hCAFE);
    grant_is("late_wide_gnt", 3'b100);
    push(t + 1, 8'h04, 8'hFE, 3'b000);
    push(t + 2, 8'h08, 8'hCA, 3'b100);
    tick();
    bus.req[2] = 1'b0;
    set_req(0, 3'd1, 1'b0, 16'h0055);
    grant_is("late_no_gnt_lo", 3'b000);
    tick();
    grant_is("late_gnt_hi", 3'b001);
    push(t + 1, 8'h02, 8'h55, 3'b001);
    tick();
    bus.req[0] = 1'b0;
    tick();

    // CLR during WR_HI cancels the high byte
    set_req(1, 3'd7, 1'b1, 16'h1234);
    grant_is("clr_gnt", 3'b010);
    push(t + 1, 8'h40, 8'h34, 3'b000);
    tick();
    bus.req[1] = 1'b0;
    tick();
    CLR = 1'b1;
    @(negedge CLK);
    check("clr_ce",   32'(bus.reg_ce), 32'h0);
    check("clr_done", 32'(bus.done),   32'h0);
    tick();
    CLR = 1'b0;
    @(negedge CLK);
    all_zero("post_clr");
    tick();
    set_req(0, 3'd3, 1'b0, 16'h003C);
    set_req(2, 3'd4, 1'b0, 16'h004D);
    grant_is("post_clr_g0", 3'b001);
    push(t + 1, 8'h08, 8'h3C, 3'b001);
    tick();
    bus.req[0] = 1'b0;
    grant_is("post_clr_g2", 3'b100);
    push(t + 1, 8'h10, 8'h4D, 3'b100);
    tick();
    bus.req[2] = 1'b0;
    repeat (3) tick();

    check("sb_drained", 32'(sbq.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Write-port controller for the CPU register bank. It shares the single 8-bit register write bus between several requesters (ALU writeback, memory load, fetch unit), picks one per grant with round-robin fairness, and drives the per-register clock enables and write data of the register_8 instances. A 16-bit write targets an even/odd register pair and takes two consecutive bus cycles, low byte first.

## Interface
- NREQ, 3, number of requesters (2..8)
- NREG, 8, number of 8-bit registers (power of two, ≥2); AW = clog2(NREG)

- CLK  in  1  clock; all state updates on rising edge
- CLR  in  1  asynchronous, active-high reset
- req  in  NREQ  request valid, one bit per requester
- req_addr  in  NREQ*AW  target register index, requester i at [i*AW +: AW]
- req_wide  in  NREQ  1 = 16-bit pair write
- req_data  in  NREQ*16  write data, requester i at [i*16 +: 16]; 8-bit writes use [7:0]
- gnt  out  NREQ  one-hot accept, combinational
- done  out  NREQ  one-cycle pulse in the final write cycle of requester i's transfer
- reg_ce  out  NREG  one-hot clock enable to the register bank
- reg_d  out  8  shared write data to the register bank
- busy  out  1  high in WR_LO/WR_HI

## Operation
- States: IDLE, WR_LO, WR_HI.
- Accept: at most one gnt bit per cycle; gnt can be high only in IDLE or in a final write cycle (WR_LO with captured wide=0, or WR_HI). Transfer occurs at the edge where req[i]&gnt[i]; addr/wide/data and requester id are captured into internal registers.
- Requesters hold req/addr/wide/data stable until gnt is seen; they may drop req or present a new request from the following cycle.
- Arbitration: round-robin from pointer p; winner = first i ≥ p (mod NREQ) with req[i]. After an accept, p = winner+1 mod NREQ. Reset p = 0.
- On accept → WR_LO. WR_LO: reg_ce[addr] = 1, reg_d = data[7:0]; for wide, addr[0] is forced to 0. WR_LO wide → WR_HI: reg_ce[addr|1] = 1, reg_d = data[15:8].
- Final write cycle: done[id] = 1; next state WR_LO if a new accept occurs in the same cycle, else IDLE.
- Outside WR_LO/WR_HI: reg_ce = 0, reg_d = 0, done = 0.
- Reset values: state IDLE, p = 0, captured regs 0, gnt/done/reg_ce/reg_d/busy all 0.

## Timing
- Request accepted in cycle T: 8-bit write → reg_ce high in T+1, register value visible T+2, done in T+1.
- Wide write: low byte in T+1, high byte in T+2, done in T+2, both bytes visible T+3.
- Back-to-back: with continuous requests, the bus writes one byte every cycle with no idle gap.
- Simultaneous requests: one grant per cycle; the others keep req high and wait. No requester waits more than NREQ-1 other transfers.
- Request arriving in WR_LO of a wide transfer: not granted until WR_HI.
- CLR mid-transfer: immediate return to IDLE; reg_ce/done drop asynchronously; the pending byte is not written; no done is issued.
- req dropped without gnt: legal; no state change.

## Structure
- Package regfile_pkg: NREG, AW, and the state enum (IDLE, WR_LO, WR_HI).
- Sub-module rr_arbiter (req vector, pointer → one-hot winner plus index), instantiated once. The FSM, capture registers and decode live in reg_write_arbiter.

## Test plan
- Single 8-bit write: req[1], addr 3, data 0x00A5 → gnt[1] in T; reg_ce = 0x08, reg_d = 0xA5, done[1] in T+1; busy low in T+2.
- Wide write: req[0], addr 5 (forced to 4), wide, data 0xBEEF → reg_ce 0x10 with 0xEF in T+1; reg_ce 0x20 with 0xBE and done[0] in T+2.
- Contention: req = 3'b111 held, all 8-bit, after reset → grants in order 0,1,2,0; reg_ce active in every cycle from T+1 on.
- Fairness after wrap: p = 2 with req = 3'b101 → gnt[2] first, then gnt[0].
- Wide + late request: wide from req[2]; req[0] raised in WR_LO → no gnt in WR_LO; gnt[0] in WR_HI; req[0] write in the next cycle.
- CLR in WR_HI of a wide write → reg_ce = 0 and no done; after release all outputs are 0, p = 0, and the next grant goes to the lowest-index requester.
